// File: rtl/matadd_cmd_scheduler_pkg.sv
// Shared types for the MatrixAddEngine command scheduler: FSM states,
// completion status codes and the queued operand record.
package matadd_cmd_scheduler_pkg;

    localparam int SCHED_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, CPL} sched_state_e;

    typedef enum logic [1:0] {
        CPL_OK       = 2'd0,
        CPL_TIMEOUT  = 2'd1,
        CPL_ZERO_LEN = 2'd2
    } cpl_status_e;

    // The tag width is a per-instance parameter, so the tag travels beside
    // this record in the FIFO word instead of being a field of it.
    typedef struct packed {
        logic [31:0] baseA;
        logic [31:0] baseB;
        logic [31:0] baseC;
        logic [31:0] length;
    } matadd_cmd_t;

endpackage

// File: rtl/matadd_cmd_scheduler_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy; the head word is
// read combinationally, so a word written this cycle is poppable next cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/matadd_cmd_scheduler.sv
// Queues matrix-add commands, issues them one at a time to the engine with a
// start pulse, guards each run with a watchdog and returns tagged completions.
module matadd_cmd_scheduler
    import matadd_cmd_scheduler_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = SCHED_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [31:0]               cmd_baseA,
    input  logic [31:0]               cmd_baseB,
    input  logic [31:0]               cmd_baseC,
    input  logic [31:0]               cmd_length,
    input  logic [TAG_W-1:0]          cmd_tag,
    output logic                      eng_start,
    output logic [31:0]               eng_baseA,
    output logic [31:0]               eng_baseB,
    output logic [31:0]               eng_baseC,
    output logic [31:0]               eng_length,
    input  logic                      eng_busy,
    input  logic                      eng_done,
    output logic                      cpl_valid,
    input  logic                      cpl_ready,
    output logic [TAG_W-1:0]          cpl_tag,
    output logic [1:0]                cpl_status,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic                      idle
);
    localparam int FW   = $bits(matadd_cmd_t) + TAG_W;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    matadd_cmd_t      push_cmd, head_cmd, ops_q;
    logic [TAG_W-1:0] head_tag, cpl_tag_q;
    logic [FW-1:0]    head_data;
    logic             fifo_full, fifo_empty, pop;
    sched_state_e     state_q;
    cpl_status_e      cpl_status_q;
    logic             eng_start_q, cpl_valid_q;
    logic [WD_W-1:0]  wdog_q;

    assign push_cmd = '{baseA: cmd_baseA, baseB: cmd_baseB,
                        baseC: cmd_baseC, length: cmd_length};
    assign {head_cmd, head_tag} = head_data;
    assign pop = (state_q == IDLE) && !fifo_empty && !eng_busy;

    sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .wdata ({push_cmd, cmd_tag}),
        .pop   (pop),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    // Gated by rst_n so every output reads 0 (idle aside) while reset is held.
    assign cmd_ready  = rst_n && !fifo_full;
    assign eng_start  = eng_start_q;
    assign eng_baseA  = ops_q.baseA;
    assign eng_baseB  = ops_q.baseB;
    assign eng_baseC  = ops_q.baseC;
    assign eng_length = ops_q.length;
    assign cpl_valid  = cpl_valid_q;
    assign cpl_tag    = cpl_tag_q;
    assign cpl_status = cpl_status_q;
    assign idle       = (q_count == '0) && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            eng_start_q  <= 1'b0;
            ops_q        <= '0;
            cpl_valid_q  <= 1'b0;
            cpl_tag_q    <= '0;
            cpl_status_q <= CPL_OK;
            wdog_q       <= '0;
        end else begin
            eng_start_q <= 1'b0;
            case (state_q)
                IDLE: if (pop) begin
                    cpl_tag_q <= head_tag;
                    if (head_cmd.length == 32'd0) begin
                        cpl_status_q <= CPL_ZERO_LEN;
                        cpl_valid_q  <= 1'b1;
                        state_q      <= CPL;
                    end else begin
                        ops_q       <= head_cmd;
                        eng_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= WAIT;
                end
                // done is tested first so it wins on the timeout cycle
                WAIT: if (eng_done) begin
                    cpl_status_q <= CPL_OK;
                    cpl_valid_q  <= 1'b1;
                    state_q      <= CPL;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    cpl_status_q <= CPL_TIMEOUT;
                    state_q      <= DRAIN;
                end else begin
                    wdog_q <= wdog_q + WD_W'(1);
                end
                DRAIN: if (!eng_busy) begin
                    cpl_valid_q <= 1'b1;
                    state_q     <= CPL;
                end
                CPL: if (cpl_ready) begin
                    cpl_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matadd_cmd_scheduler.sv
// Directed bench for matadd_cmd_scheduler with a behavioural engine model and
// a completion monitor; expected values are hand-derived per scenario.
module tb_matadd_cmd_scheduler;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 32;
    localparam int ENG_LAT = 10;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_baseA, cmd_baseB, cmd_baseC, cmd_length;
    logic [3:0]  cmd_tag;
    logic        eng_start, eng_busy, eng_done;
    logic [31:0] eng_baseA, eng_baseB, eng_baseC, eng_length;
    logic        cpl_valid, cpl_ready;
    logic [3:0]  cpl_tag;
    logic [1:0]  cpl_status;
    logic [2:0]  q_count;
    logic        idle;

    int n_cmp = 0;
    int n_err = 0;

    // engine model controls: mode 0 = done after ENG_LAT, 1 = hang while hung,
    // 2 = busy for 3 cycles then drop without ever pulsing done
    int   eng_mode = 0;
    int   eng_cnt = 0;
    int   eng_starts = 0;
    bit   hung = 0, late_done = 0, force_busy = 0;

    logic [3:0] mon_tag[$];
    logic [1:0] mon_st[$];

    matadd_cmd_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_baseA(cmd_baseA), .cmd_baseB(cmd_baseB), .cmd_baseC(cmd_baseC),
        .cmd_length(cmd_length), .cmd_tag(cmd_tag),
        .eng_start(eng_start), .eng_baseA(eng_baseA), .eng_baseB(eng_baseB),
        .eng_baseC(eng_baseC), .eng_length(eng_length),
        .eng_busy(eng_busy), .eng_done(eng_done),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
        .cpl_status(cpl_status), .q_count(q_count), .idle(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // behavioural engine, updated just after each falling edge
    initial begin
        eng_busy = 1'b0;
        eng_done = 1'b0;
        forever begin
            @(negedge clk); #1;
            eng_done = 1'b0;
            if (late_done) begin
                eng_done  = 1'b1;
                late_done = 1'b0;
            end
            if (!rst_n) begin
                eng_cnt = 0;
                hung    = 1'b0;
            end else if (eng_start) begin
                eng_starts++;
                if (eng_mode == 1) hung = 1'b1;
                else eng_cnt = (eng_mode == 0) ? ENG_LAT : 3;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0 && eng_mode == 0) eng_done = 1'b1;
            end
            eng_busy = force_busy || (eng_cnt > 0) || hung;
        end
    end

    // completion monitor: records each accepted handshake
    initial begin
        forever begin
            @(negedge clk); #1;
            if (rst_n && cpl_valid && cpl_ready) begin
                mon_tag.push_back(cpl_tag);
                mon_st.push_back(cpl_status);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, b, c, len, input logic [3:0] tag);
        int k = 0;
        cmd_valid = 1'b1;
        cmd_baseA = a; cmd_baseB = b; cmd_baseC = c;
        cmd_length = len; cmd_tag = tag;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) chk("push_tmo", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!eng_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", eng_start, 1);
    endtask

    task automatic wait_q(input int n, input int budget);
        int k = 0;
        while (mon_tag.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (mon_tag.size() < n) chk("cpl_wait_tmo", mon_tag.size(), n);
    endtask

    task automatic pop_cpl(input string nm, input logic [3:0] et, input logic [1:0] es);
        logic [3:0] t;
        logic [1:0] s;
        if (mon_tag.size() == 0) begin
            chk({nm, "_present"}, mon_tag.size(), 1);
        end else begin
            t = mon_tag.pop_front();
            s = mon_st.pop_front();
            chk({nm, "_tag"}, t, et);
            chk({nm, "_st"}, s, es);
        end
    endtask

    initial begin
        int n, s0;
        bit stable;
        rst_n = 1'b0; cmd_valid = 1'b0; cpl_ready = 1'b1;
        cmd_baseA = '0; cmd_baseB = '0; cmd_baseC = '0; cmd_length = '0; cmd_tag = '0;

        // reset state
        #1;
        chk("rst_idle", idle, 1);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_qcount", q_count, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_cplv", cpl_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);

        // single command, engine done 10 cycles after start
        push(32'd16, 32'd64, 32'd128, 32'd6, 4'd3);
        wait_start(n);
        chk("t1_issue_lat", n, 1);
        chk("t1_baseA", eng_baseA, 16);
        chk("t1_baseB", eng_baseB, 64);
        chk("t1_baseC", eng_baseC, 128);
        chk("t1_len", eng_length, 6);
        @(negedge clk);
        chk("t1_start_pulse", eng_start, 0);
        wait_q(1, 40);
        pop_cpl("t1", 4'd3, 2'd0);
        chk("t1_starts", eng_starts, 1);
        repeat (2) @(negedge clk);
        chk("t1_idle", idle, 1);

        // fill FIFO while engine busy, then drain in order
        s0 = eng_starts;
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h100 + i, 32'h200 + i, 32'h300 + i, 32'd4, 4'(i));
        chk("t2_full_count", q_count, 4);
        chk("t2_full_ready", cmd_ready, 0);
        chk("t2_no_issue", eng_starts, s0);
        force_busy = 1'b0;
        push(32'h104, 32'h204, 32'h304, 32'd4, 4'd4);
        wait_q(5, 400);
        for (int i = 0; i < 5; i++) pop_cpl($sformatf("t2_c%0d", i), 4'(i), 2'd0);
        chk("t2_starts", eng_starts, s0 + 5);

        // zero-length command
        s0 = eng_starts;
        push(32'd1, 32'd2, 32'd3, 32'd0, 4'd7);
        n = 0;
        while (!cpl_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t3_lat_ok", (n >= 1 && n <= 2), 1);
        wait_q(1, 5);
        pop_cpl("t3", 4'd7, 2'd2);
        chk("t3_no_start", eng_starts, s0);

        // hung engine: timeout, drain until busy falls, late done ignored
        s0 = eng_starts;
        eng_mode = 1;
        push(32'd10, 32'd20, 32'd30, 32'd4, 4'd5);
        push(32'd11, 32'd21, 32'd31, 32'd4, 4'd6);
        repeat (50) @(negedge clk);
        chk("t4_no_cpl", mon_tag.size(), 0);
        chk("t4_no_issue", eng_starts, s0 + 1);
        eng_mode = 0;
        hung = 1'b0;
        late_done = 1'b1;
        wait_q(2, 100);
        pop_cpl("t4_a", 4'd5, 2'd1);
        pop_cpl("t4_b", 4'd6, 2'd0);
        repeat (20) @(negedge clk);
        chk("t4_no_extra", mon_tag.size(), 0);

        // exact watchdog length: ISSUE + 32 WAIT + DRAIN before cpl_valid
        eng_mode = 2;
        push(32'd12, 32'd22, 32'd32, 32'd4, 4'd9);
        wait_start(n);
        n = 0;
        while (!cpl_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("t4_tmo_lat", n, 34);
        wait_q(1, 5);
        pop_cpl("t4_c", 4'd9, 2'd1);
        eng_mode = 0;

        // completion back-pressure
        s0 = eng_starts;
        cpl_ready = 1'b0;
        push(32'd40, 32'd50, 32'd60, 32'd4, 4'd10);
        push(32'd41, 32'd51, 32'd61, 32'd4, 4'd11);
        n = 0;
        while (!cpl_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5_cplv", cpl_valid, 1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(cpl_valid && cpl_tag == 4'd10 && cpl_status == 2'd0 && !eng_start)) stable = 1'b0;
        end
        chk("t5_hold_stable", stable, 1);
        chk("t5_one_start", eng_starts, s0 + 1);
        chk("t5_qcount", q_count, 1);
        cpl_ready = 1'b1;
        wait_q(2, 100);
        pop_cpl("t5_a", 4'd10, 2'd0);
        pop_cpl("t5_b", 4'd11, 2'd0);

        // reset while in WAIT with three commands queued
        s0 = eng_starts;
        eng_mode = 1;
        for (int i = 1; i <= 4; i++) push(32'h1000 + i, 32'h2000, 32'h3000, 32'd4, 4'(i));
        repeat (3) @(negedge clk);
        chk("t6_one_start", eng_starts, s0 + 1);
        chk("t6_queued", q_count, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_qcount", q_count, 0);
        chk("t6_rst_idle", idle, 1);
        chk("t6_rst_baseA", eng_baseA, 0);
        chk("t6_rst_start", eng_start, 0);
        chk("t6_rst_ready", cmd_ready, 0);
        @(negedge clk);
        eng_mode = 0;
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t6_no_cpl", mon_tag.size(), 0);
        chk("t6_no_issue", eng_starts, s0 + 1);
        chk("t6_idle", idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
